keypad_scanner: RTL

Scans a 4x4 matrix keypad, debounces presses and releases, and emits one key_valid pulse with a 4-bit key_code per physical press. Sits directly upstream of montar_pin and drives its key_valid/key_code inputs. Keys 0-9 map to digits, A-D to 0xA-0xD, '*' to 0xE, '#' to 0xF (the confirm key).

---
 rtl/keypad_scanner_if.sv | 11 +
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines and decoded key event bundle for keypad_scanner.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;

  modport master (input row_in, output col_out, output key_valid, output key_code);
  modport slave  (output row_in, input col_out, input key_valid, input key_code);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce; one key_valid pulse per press.
// Optional auto-repeat for digit keys: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);

  if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("keypad_scanner: parameter below minimum");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESS, HELD} state_t;

  state_t          state, state_n;
  logic [3:0]      row_s1, row_s2;
  logic [1:0]      col_idx, col_idx_n;
  logic [SW-1:0]   scan_cnt, scan_cnt_n;
  logic [DW-1:0]   deb_cnt, deb_cnt_n;
  logic [3:0]      cap_row, cap_row_n;
  logic            key_valid_q, key_valid_n;
  logic [3:0]      key_code_q, key_code_n;
  logic            one_low;
  logic            rep_fire;

  function automatic logic [3:0] key_map(input logic [3:0] row, input logic [1:0] col);
    logic [1:0] r;
    logic [3:0] code;
    r = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row[i]) r = 2'(i);
    end
    case ({r, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign one_low = ($countones(~row_s2) == 1);

  always_comb begin
    state_n     = state;
    col_idx_n   = col_idx;
    scan_cnt_n  = scan_cnt;
    deb_cnt_n   = deb_cnt;
    cap_row_n   = cap_row;
    key_valid_n = 1'b0;
    key_code_n  = key_code_q;
    case (state)
      SCAN: begin
        if (scan_cnt == SW'(SCAN_DIV - 1)) begin
          scan_cnt_n = '0;
          if (one_low) begin
            cap_row_n = row_s2;
            deb_cnt_n = '0;
            state_n   = DEBOUNCE;
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end else begin
          scan_cnt_n = scan_cnt + SW'(1);
        end
      end
      DEBOUNCE: begin
        if (row_s2 != cap_row) begin
          state_n    = SCAN;
          col_idx_n  = col_idx + 2'd1;
          scan_cnt_n = '0;
          deb_cnt_n  = '0;
        end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          // Registered pulse lands in the PRESS cycle itself.
          state_n     = PRESS;
          deb_cnt_n   = '0;
          key_valid_n = 1'b1;
          key_code_n  = key_map(cap_row, col_idx);
        end else begin
          deb_cnt_n = deb_cnt + DW'(1);
        end
      end
      PRESS: begin
        state_n   = HELD;
        deb_cnt_n = '0;
      end
      HELD: begin
        if (row_s2 == '1) begin
          if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            state_n    = SCAN;
            col_idx_n  = col_idx + 2'd1;
            scan_cnt_n = '0;
            deb_cnt_n  = '0;
          end else begin
            deb_cnt_n = deb_cnt + DW'(1);
          end
        end else begin
          deb_cnt_n = '0;
          if (rep_fire) key_valid_n = 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= SCAN;
      row_s1      <= '1;
      row_s2      <= '1;
      col_idx     <= '0;
      scan_cnt    <= '0;
      deb_cnt     <= '0;
      cap_row     <= '1;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      state       <= state_n;
      row_s1      <= kp.row_in;
      row_s2      <= row_s1;
      col_idx     <= col_idx_n;
      scan_cnt    <= scan_cnt_n;
      deb_cnt     <= deb_cnt_n;
      cap_row     <= cap_row_n;
      key_valid_q <= key_valid_n;
      key_code_q  <= key_code_n;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [RW-1:0] hold_cnt, hold_cnt_n, rep_target;
  logic          rep_armed, rep_armed_n;
  logic          rep_stop, rep_stop_n;

  // One counter serves both phases: it clears on each pulse and the target
  // switches from the initial delay to the period after the first repeat.
  always_comb begin
    hold_cnt_n  = hold_cnt;
    rep_armed_n = rep_armed;
    rep_stop_n  = rep_stop;
    rep_fire    = 1'b0;
    rep_target  = rep_armed ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
    if (state == PRESS) begin
      hold_cnt_n  = RW'(1);
      rep_armed_n = 1'b0;
      rep_stop_n  = (key_code_q > 4'd9);
    end else if (state == HELD && !rep_stop) begin
      if (row_s2 == '1) begin
        rep_stop_n = 1'b1;
      end else if (hold_cnt + RW'(1) == rep_target) begin
        rep_fire    = 1'b1;
        hold_cnt_n  = '0;
        rep_armed_n = 1'b1;
      end else begin
        hold_cnt_n = hold_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt  <= '0;
      rep_armed <= 1'b0;
      rep_stop  <= 1'b0;
    end else begin
      hold_cnt  <= hold_cnt_n;
      rep_armed <= rep_armed_n;
      rep_stop  <= rep_stop_n;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign kp.col_out   = ~(4'b0001 << col_idx);
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;

endmodule
